// File: rtl/memory_arbiter.sv
// Three-way arbiter (loader, CPU data, CPU fetch) in front of a single-port memory:
// one combinational grant per cycle, one-stage issue register, registered read return.
module memory_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic              dm_req,
  input  logic              if_req,
  input  logic              ld_we,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              ld_ack,
  output logic              dm_ack,
  output logic              if_ack,
  output logic              ld_rvalid,
  output logic              dm_rvalid,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant_id,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [2:0]        starve_cnt
);

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_LD     = 2'd1;
  localparam logic [1:0] SRC_DM     = 2'd2;
  localparam logic [1:0] SRC_IF     = 2'd3;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic              iss_valid_q, iss_valid_d;
  logic [1:0]        iss_src_q, iss_src_d;
  logic              iss_we_q, iss_we_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;
  logic [1:0]        ret_src_q, ret_src_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        starve_q, starve_d;
  logic [1:0]        win;

  // Handshake: a requester holds req and its qualifiers until it sees its ack;
  // the ack cycle is the transfer, and req low before ack withdraws the request.
  always_comb begin
    win = SRC_NONE;
    if (reset_n) begin
      if (if_req && (starve_q == STARVE_MAX)) win = SRC_IF;
      else if (ld_req)                         win = SRC_LD;
      else if (dm_req)                         win = SRC_DM;
      else if (if_req)                         win = SRC_IF;
    end
  end

  assign ld_ack = (win == SRC_LD);
  assign dm_ack = (win == SRC_DM);
  assign if_ack = (win == SRC_IF);

  always_comb begin
    iss_valid_d = (win != SRC_NONE);
    iss_src_d   = win;
    iss_we_d    = 1'b0;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    case (win)
      SRC_LD: begin
        iss_we_d    = ld_we;
        iss_addr_d  = ld_addr;
        iss_wdata_d = ld_wdata;
      end
      SRC_DM: begin
        iss_we_d    = dm_we;
        iss_addr_d  = dm_addr;
        iss_wdata_d = dm_wdata;
      end
      SRC_IF:  iss_addr_d = if_addr;
      default: ;
    endcase

    rdata_d   = rdata_q;
    ret_src_d = SRC_NONE;
    if (iss_valid_q && !iss_we_q) begin
      rdata_d   = mem_data_out;
      ret_src_d = iss_src_q;
    end

    // Fetch starvation: count denied fetch cycles, saturating at the promotion point.
    starve_d = 3'd0;
    if (if_req && !if_ack)
      starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 3'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_q <= 1'b0;
      iss_src_q   <= SRC_NONE;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      ret_src_q   <= SRC_NONE;
      rdata_q     <= '0;
      starve_q    <= 3'd0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_src_q   <= iss_src_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      ret_src_q   <= ret_src_d;
      rdata_q     <= rdata_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_address = iss_addr_q;
  assign mem_data_in = iss_wdata_q;
  assign mem_we      = iss_valid_q & iss_we_q;
  assign grant_id    = iss_src_q;
  assign rdata       = rdata_q;
  assign ld_rvalid   = (ret_src_q == SRC_LD);
  assign dm_rvalid   = (ret_src_q == SRC_DM);
  assign if_rvalid   = (ret_src_q == SRC_IF);
  assign starve_cnt  = starve_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port 256x16 unified memory between three requesters: the program loader (boot/debug download), the CPU data path (load/store) and the CPU instruction fetch. It arbitrates each cycle, registers the winning request into a one-stage issue pipeline, drives the memory's address/write-enable/data-in from that stage, and returns registered read data one cycle later. Throughput is one access per cycle. The block sits between the CPU core/loader and the memory, and is the memory's only master.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is promoted (1..7)

- clock  in  1  system clock, rising edge; same clock as CPU and memory
- reset_n  in  1  asynchronous, active-low reset
- ld_req, dm_req, if_req  in  1 each  access request; held with its qualifiers until the matching ack
- ld_we, dm_we  in  1 each  1 = write, 0 = read (fetch is read-only)
- ld_addr, dm_addr, if_addr  in  ADDR_W each  access address
- ld_wdata, dm_wdata  in  DATA_W each  write data
- ld_ack, dm_ack, if_ack  out  1 each  request accepted this cycle (combinational, one-hot or zero)
- ld_rvalid, dm_rvalid, if_rvalid  out  1 each  rdata holds this requester's read result (registered)
- rdata  out  DATA_W  registered read data, shared by all requesters
- grant_id  out  2  source of the access in the issue stage: 0 none, 1 ld, 2 dm, 3 if
- mem_address  out  ADDR_W  to memory address
- mem_we  out  1  to memory write enable
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out (combinational read)

## Operation
- Arbitration is combinational in cycle N over the current req lines:
  - Normal priority: ld > dm > if.
  - Promoted priority: when starve_cnt == STARVE_LIMIT and if_req = 1, if wins over both ld and dm.
- At most one ack is high per cycle. The winner's ack is high in N. At the end of N, its we/addr/wdata and source are captured into the issue stage.
- Issue stage (cycle N+1):
  - mem_address = captured addr; mem_data_in = captured wdata.
  - mem_we = captured we & valid.
  - grant_id = source.
  - Memory writes at the end of N+1.
- Read return:
  - For a read, rdata is loaded from mem_data_out at the end of N+1.
  - The matching x_rvalid is high for exactly cycle N+2.
  - rdata holds its value until the next read completes.
  - Writes produce no rvalid.
- Empty issue stage: mem_we = 0, grant_id = 0. mem_address and mem_data_in hold their last value.
- Starvation counter (3 bits):
  - Increments, saturating at STARVE_LIMIT, in each cycle if_req = 1 and if_ack = 0.
  - Clears on if_ack or when if_req = 0.
- Requester contract: req, we, addr and wdata are stable from req rise until ack. Dropping req before ack cancels it with no side effect.
- Every grant is final. There is no abort path.

## Timing
- Read latency: request accepted in N, data plus rvalid in N+2.
- Write latency: memory updated at the end of N+1.
- Back-to-back accesses from any mix of requesters issue every cycle.
- Read-after-write to the same address, write accepted N and read accepted N+1: the read returns the new data, because the write commits before the read's issue cycle. No forwarding is required.
- Simultaneous requests: exactly one ack per cycle; the losers keep req high and are served in later cycles.
- Reset values (asynchronous, while reset_n = 0):
  - All acks and rvalids 0.
  - mem_we = 0; grant_id = 0.
  - rdata, mem_address and mem_data_in = 0.
  - starve_cnt = 0; issue stage empty.
- Acks are gated low while reset_n = 0.
- Reset mid-operation: an access in the issue stage is dropped, so no write occurs even if it was acked. A pending rvalid is dropped.
- First possible ack: the first cycle after reset_n rises.

## Test plan
- Single read: memory[0x10] = 0xBEEF; dm read 0x10 accepted cycle 0 -> mem_address = 0x10 in cycle 1, rdata = 0xBEEF with dm_rvalid = 1 in cycle 2 only.
- Write then read: ld write 0x20 = 0x1234 in cycle 0, ld read 0x20 in cycle 1 -> mem_we = 1 in cycle 1 only; ld_rvalid in cycle 3 with rdata = 0x1234.
- Priority: ld, dm and if all request in the same cycle, holding until acked -> acks in the order ld, dm, if on three consecutive cycles; grant_id sequence 1, 2, 3 one cycle later.
- Starvation, STARVE_LIMIT = 4: dm requests continuously (re-requesting after each ack) while if_req is held -> if_ack is 0 for 4 cycles and high on the 5th; starve_cnt returns to 0 afterwards.
- Reset mid-write: dm write 0x30 = 0xAAAA acked, then reset_n pulled low before the issue-cycle clock edge -> mem_we drops immediately, memory[0x30] is unchanged, and all outputs read 0.
- Cancel: if_req high for one cycle while losing to dm, then dropped -> no if_ack and no if_rvalid; starve_cnt returns to 0.
